// File: rtl/microwave_pkg.sv
// Shared constants for the microwave cook-cycle timer: FSM encodings, BCD digit
// limits, the M:SS time record and the keypad acceptance rule.
package microwave_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_SET   = 3'd1;
  localparam logic [STATE_W-1:0] ST_COOK  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  localparam logic [3:0] BCD_MAX_U = 4'd9;
  localparam logic [3:0] BCD_MAX_T = 4'd5;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } bcd_time_t;

  // A shifted-in key must be a BCD digit and must not push an illegal value into SEC_T.
  function automatic logic key_accept(input logic [3:0] digit, input logic [3:0] old_sec_u);
    return (digit <= BCD_MAX_U) && (old_sec_u <= BCD_MAX_T);
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_bcd_down_digit.sv
// Single BCD down-counting digit with parallel load and ripple borrow, wrapping
// 0 -> MAX when a borrow reaches it.
module bcd_down_digit
  import microwave_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_U
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_en_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       borrow_o,
  output logic       zero_o
);

  logic [3:0] digit_q, digit_d;

  assign zero_o   = (digit_q == 4'd0);
  assign borrow_o = dec_en_i & borrow_i & zero_o;
  assign digit_o  = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (dec_en_i && borrow_i) begin
      digit_d = zero_o ? MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-cycle controller: keypad entry, START/STOP/door sequencing and
// an M:SS countdown. Define DONE_BEEP_EN to hold the beeper in DONE for BEEP_SECONDS.
//
// state | meaning
// IDLE  | time 0:00, waiting for keys
// SET   | time entered, not running
// COOK  | counting down, magnetron on while door closed
// PAUSE | halted by STOP or door, time held
// DONE  | countdown reached 0:00
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int CLK_PER_SEC  = 1000,
  parameter int BEEP_SECONDS = 3
) (
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic               key_valid_i,
  input  logic [3:0]         key_digit_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               door_open_i,
  output logic [3:0]         min_o,
  output logic [3:0]         sec_t_o,
  output logic [3:0]         sec_u_o,
  output logic [STATE_W-1:0] state_o,
  output logic               mag_on_o,
  output logic               beep_o
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_PER_SEC - 1);

  if (CLK_PER_SEC < 2 || BEEP_SECONDS < 1) begin : g_param_check
    $error("microwave_timer_ctrl: CLK_PER_SEC must be >= 2 and BEEP_SECONDS >= 1");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tick;
  logic               time_ld;
  bcd_time_t          time_ld_val;
  logic               done_exit;

  logic [3:0] min_q, sec_t_q, sec_u_q;
  logic       min_zero, sec_t_zero, sec_u_zero;
  logic       sec_u_borrow, sec_t_borrow, min_borrow;
  logic       time_zero, time_one, key_ok;
  bcd_time_t  key_shift;

  assign time_zero = min_zero & sec_t_zero & sec_u_zero;
  assign time_one  = min_zero & sec_t_zero & (sec_u_q == 4'd1);
  assign key_ok    = key_valid_i & key_accept(key_digit_i, sec_u_q);
  assign key_shift = '{min: sec_t_q, sec_t: sec_u_q, sec_u: key_digit_i};

  // Higher-priority inputs (STOP > door > START > key) pre-empt lower ones.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick        = 1'b0;
    time_ld     = 1'b0;
    time_ld_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_i && !door_open_i && !start_i && key_ok) begin
          time_ld     = 1'b1;
          time_ld_val = key_shift;
          state_d     = ST_SET;
        end
      end
      ST_SET: begin
        if (stop_i) begin
          time_ld = 1'b1;
          state_d = ST_IDLE;
        end else if (!door_open_i) begin
          if (start_i) begin
            if (!time_zero) begin
              presc_d = '0;
              state_d = ST_COOK;
            end
          end else if (key_ok) begin
            time_ld     = 1'b1;
            time_ld_val = key_shift;
          end
        end
      end
      ST_COOK: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else begin
          tick    = (presc_q == PRESC_TC);
          presc_d = tick ? '0 : (presc_q + 1'b1);
          // The door does not cancel a coinciding tick; it can pause at 0:00.
          if (door_open_i) begin
            presc_d = presc_q;
            state_d = ST_PAUSE;
          end else if (tick && (time_one || min_borrow)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          time_ld = 1'b1;
          state_d = ST_IDLE;
        end else if (!door_open_i && start_i && !time_zero) begin
          presc_d = '0;
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (done_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  bcd_down_digit #(.MAX(BCD_MAX_U)) u_sec_u (
    .clk_i      (clk_i),
    .rst_i      (clear_i),
    .load_i     (time_ld),
    .load_val_i (time_ld_val.sec_u),
    .dec_en_i   (tick),
    .borrow_i   (1'b1),
    .digit_o    (sec_u_q),
    .borrow_o   (sec_u_borrow),
    .zero_o     (sec_u_zero)
  );

  bcd_down_digit #(.MAX(BCD_MAX_T)) u_sec_t (
    .clk_i      (clk_i),
    .rst_i      (clear_i),
    .load_i     (time_ld),
    .load_val_i (time_ld_val.sec_t),
    .dec_en_i   (tick),
    .borrow_i   (sec_u_borrow),
    .digit_o    (sec_t_q),
    .borrow_o   (sec_t_borrow),
    .zero_o     (sec_t_zero)
  );

  bcd_down_digit #(.MAX(BCD_MAX_U)) u_min (
    .clk_i      (clk_i),
    .rst_i      (clear_i),
    .load_i     (time_ld),
    .load_val_i (time_ld_val.min),
    .dec_en_i   (tick),
    .borrow_i   (sec_t_borrow),
    .digit_o    (min_q),
    .borrow_o   (min_borrow),
    .zero_o     (min_zero)
  );

`ifdef DONE_BEEP_EN
  localparam int BEEP_CYC = BEEP_SECONDS * CLK_PER_SEC;
  localparam int BW       = $clog2(BEEP_CYC);

  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q;

  assign done_exit = stop_i | key_valid_i | (beep_cnt_q == '0);

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (state_q != ST_DONE && state_d == ST_DONE) begin
      beep_cnt_d = BW'(BEEP_CYC - 1);
    end else if (state_q == ST_DONE && beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= (state_d == ST_DONE);
    end
  end

  assign beep_o = beep_q;
`else
  assign done_exit = 1'b1;
  assign beep_o    = 1'b0;
`endif

  assign min_o    = min_q;
  assign sec_t_o  = sec_t_q;
  assign sec_u_o  = sec_u_q;
  assign state_o  = state_q;
  assign mag_on_o = (state_q == ST_COOK) & ~door_open_i;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Table-driven bench for microwave_timer_ctrl (CLK_PER_SEC=4, BEEP_SECONDS=2),
// expected outputs queued at drive time and compared one edge later.
module tb_microwave_timer_ctrl;

  localparam int N  = 4;
  localparam int BS = 2;
`ifdef DONE_BEEP_EN
  localparam logic BEEP_ON  = 1'b1;
  localparam int   DONE_CYC = BS * N;
`else
  localparam logic BEEP_ON  = 1'b0;
  localparam int   DONE_CYC = 1;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sp;
    logic       dr;
    logic [2:0] e_state;
    logic [3:0] e_min;
    logic [3:0] e_st;
    logic [3:0] e_su;
    logic       e_mag;
    logic       e_beep;
  } vec_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_open;
  logic [3:0] min_o, sec_t_o, sec_u_o;
  logic [2:0] state_o;
  logic       mag_on_o, beep_o;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  microwave_timer_ctrl #(.CLK_PER_SEC(N), .BEEP_SECONDS(BS)) dut (
    .clk_i       (clk),
    .clear_i     (clear),
    .key_valid_i (key_valid),
    .key_digit_i (key_digit),
    .start_i     (start),
    .stop_i      (stop),
    .door_open_i (door_open),
    .min_o       (min_o),
    .sec_t_o     (sec_t_o),
    .sec_u_o     (sec_u_o),
    .state_o     (state_o),
    .mag_on_o    (mag_on_o),
    .beep_o      (beep_o)
  );

  function automatic vec_t mk(input logic kv, input logic [3:0] kd, input logic st,
                              input logic sp, input logic dr, input logic [2:0] es,
                              input logic [3:0] em, input logic [3:0] et, input logic [3:0] eu,
                              input logic emag, input logic ebeep);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.dr = dr;
    v.e_state = es; v.e_min = em; v.e_st = et; v.e_su = eu;
    v.e_mag = emag; v.e_beep = ebeep;
    return v;
  endfunction

  function automatic logic [16:0] pack_exp(input vec_t v);
    return {v.e_state, v.e_min, v.e_st, v.e_su, v.e_mag, v.e_beep};
  endfunction

  task automatic check(input string name, input logic [16:0] exp_v);
    logic [16:0] act;
    act = {state_o, min_o, sec_t_o, sec_u_o, mag_on_o, beep_o};
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got state=%0d time=%0d:%0d%0d mag=%0b beep=%0b, want state=%0d time=%0d:%0d%0d mag=%0b beep=%0b",
               name, act[16:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp_v[16:14], exp_v[13:10], exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    key_valid = v.kv;
    key_digit = v.kd;
    start     = v.st;
    stop      = v.sp;
    door_open = v.dr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, pack_exp(e));
  endtask

  // Idle cycle while cooking, display derived from elapsed edges since (re)start.
  task automatic cook_run(input int secs0, input int edges, input string name);
    int secs;
    for (int k = 1; k <= edges; k++) begin
      secs = secs0 - k / N;
      if (secs == 0)
        apply(mk(0, 0, 0, 0, 0, S_DONE, 0, 0, 0, 0, BEEP_ON), $sformatf("%s_done", name));
      else
        apply(mk(0, 0, 0, 0, 0, S_COOK, 4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10), 1, 0),
              $sformatf("%s_k%0d", name, k));
    end
  endtask

  task automatic done_tail(input string name);
    for (int i = 1; i < DONE_CYC; i++)
      apply(mk(0, 0, 0, 0, 0, S_DONE, 0, 0, 0, 0, 1), $sformatf("%s_beep%0d", name, i));
    apply(mk(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0), $sformatf("%s_idle", name));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; door_open = 1'b0;
    #1;
    check("reset", {S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    clear = 1'b0;

    // key entry, illegal keys, ignored STARTs, then 1:00 into COOK
    tbl.push_back(mk(1, 1,  0, 0, 0, S_SET,  0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0, 0, S_SET,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5,  0, 0, 0, S_SET,  1, 0, 5, 0, 0));
    tbl.push_back(mk(1, 12, 0, 0, 0, S_SET,  1, 0, 5, 0, 0));
    tbl.push_back(mk(1, 7,  0, 0, 0, S_SET,  0, 5, 7, 0, 0));
    tbl.push_back(mk(1, 6,  0, 0, 0, S_SET,  0, 5, 7, 0, 0));
    tbl.push_back(mk(0, 0,  1, 0, 1, S_SET,  0, 5, 7, 0, 0));
    tbl.push_back(mk(0, 0,  0, 1, 0, S_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  1, 0, 0, S_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0, 0, S_SET,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  1, 0, 0, S_SET,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 1, 0, S_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  0, 0, 0, S_SET,  0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0, 0, S_SET,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0, 0, S_SET,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  1, 0, 0, S_COOK, 1, 0, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // 1:00 runs to DONE 240 edges after START
    cook_run(60, 240, "cook60");
    done_tail("cook60");

    // 0:03, door opens on cycle 6, resume restarts the second
    apply(mk(1, 3, 0, 0, 0, S_SET,  0, 0, 3, 0, 0), "d_key");
    apply(mk(0, 0, 1, 0, 0, S_COOK, 0, 0, 3, 1, 0), "d_start");
    cook_run(3, 5, "d_run");
    door_open = 1'b1;
    #1;
    check("d_mag_comb", {S_COOK, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0});
    apply(mk(0, 0, 0, 0, 1, S_PAUSE, 0, 0, 2, 0, 0), "d_pause");
    apply(mk(0, 0, 0, 0, 0, S_PAUSE, 0, 0, 2, 0, 0), "d_closed");
    apply(mk(0, 0, 1, 0, 0, S_COOK,  0, 0, 2, 1, 0), "d_resume");
    cook_run(2, 8, "d_rerun");
`ifdef DONE_BEEP_EN
    apply(mk(0, 0, 0, 0, 0, S_DONE, 0, 0, 0, 0, 1), "d_beep");
    apply(mk(0, 0, 0, 1, 0, S_IDLE, 0, 0, 0, 0, 0), "d_stop_beep");
`else
    apply(mk(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0), "d_idle");
`endif

    // 0:01 cook, key press in DONE
    apply(mk(1, 1, 0, 0, 0, S_SET,  0, 0, 1, 0, 0), "k_key");
    apply(mk(0, 0, 1, 0, 0, S_COOK, 0, 0, 1, 1, 0), "k_start");
    cook_run(1, 4, "k_run");
`ifdef DONE_BEEP_EN
    apply(mk(1, 5, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0), "k_key_in_done");
    apply(mk(1, 5, 0, 0, 0, S_SET,  0, 0, 5, 0, 0), "k_key_after");
    apply(mk(0, 0, 0, 1, 0, S_IDLE, 0, 0, 0, 0, 0), "k_stop");
`else
    apply(mk(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0), "k_idle");
`endif

    // 0:01 again, full beep length
    apply(mk(1, 1, 0, 0, 0, S_SET,  0, 0, 1, 0, 0), "b_key");
    apply(mk(0, 0, 1, 0, 0, S_COOK, 0, 0, 1, 1, 0), "b_start");
    cook_run(1, 4, "b_run");
    done_tail("b");

    // door opens on the tick that reaches 0:00
    apply(mk(1, 1, 0, 0, 0, S_SET,   0, 0, 1, 0, 0), "z_key");
    apply(mk(0, 0, 1, 0, 0, S_COOK,  0, 0, 1, 1, 0), "z_start");
    cook_run(1, 3, "z_run");
    apply(mk(0, 0, 0, 0, 1, S_PAUSE, 0, 0, 0, 0, 0), "z_door_tick");
    apply(mk(0, 0, 1, 0, 0, S_PAUSE, 0, 0, 0, 0, 0), "z_start_zero");
    apply(mk(0, 0, 0, 1, 0, S_IDLE,  0, 0, 0, 0, 0), "z_stop");

    // STOP on a tick suppresses the decrement
    apply(mk(1, 2, 0, 0, 0, S_SET,   0, 0, 2, 0, 0), "s_key");
    apply(mk(0, 0, 1, 0, 0, S_COOK,  0, 0, 2, 1, 0), "s_start");
    cook_run(2, 3, "s_run");
    apply(mk(0, 0, 0, 1, 0, S_PAUSE, 0, 0, 2, 0, 0), "s_stop_tick");
    apply(mk(0, 0, 1, 0, 0, S_COOK,  0, 0, 2, 1, 0), "s_resume");
    cook_run(2, 4, "s_rerun");
    apply(mk(0, 0, 0, 1, 0, S_PAUSE, 0, 0, 1, 0, 0), "s_pause");
    apply(mk(0, 0, 0, 1, 0, S_IDLE,  0, 0, 0, 0, 0), "s_cancel");

    // CLEAR mid-COOK at 0:30
    apply(mk(1, 3, 0, 0, 0, S_SET,  0, 0, 3, 0, 0), "c_key3");
    apply(mk(1, 0, 0, 0, 0, S_SET,  0, 3, 0, 0, 0), "c_key0");
    apply(mk(0, 0, 1, 0, 0, S_COOK, 0, 3, 0, 1, 0), "c_start");
    cook_run(30, 2, "c_run");
    #2;
    clear = 1'b1;
    #1;
    check("c_clear_async", {S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0});
    clear = 1'b0;
    apply(mk(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0), "c_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Cook-cycle controller for the microwave timer. Takes keypad digit entry, START/STOP buttons and the door switch. Sequences a cascaded M:SS down-counter (minutes 0–9, seconds-tens 0–5, seconds-units 0–9) from an internal one-second prescaler. Drives the magnetron enable and the end-of-cycle beeper. Sits between the front-panel input logic and the display/power stage.

## Interface

Parameters:
- CLK_PER_SEC, 1000: clock cycles per countdown second; ≥2.
- BEEP_SECONDS, 3: beeper duration in seconds (only with DONE_BEEP_EN).

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, rising edge.
- CLEAR  in  1  asynchronous active-high reset.
- KEY_VALID  in  1  one-cycle strobe, KEY_DIGIT valid.
- KEY_DIGIT  in  4  BCD digit 0–9.
- START  in  1  one-cycle start/resume strobe.
- STOP  in  1  one-cycle stop/cancel strobe.
- DOOR_OPEN  in  1  level, 1 = door open.
- MIN  out  4  minutes digit.
- SEC_T  out  4  seconds-tens digit (0–5).
- SEC_U  out  4  seconds-units digit.
- STATE  out  3  current FSM state encoding.
- MAG_ON  out  1  magnetron enable.
- BEEP  out  1  beeper drive.

## Operation

- States:
  - IDLE=0: time 0:00.
  - SET=1: time entered, not running.
  - COOK=2: counting down.
  - PAUSE=3: halted, time held.
  - DONE=4: finished.
- Input priority in any state, per cycle: STOP > DOOR_OPEN > START > KEY_VALID.
- Key entry (IDLE, SET only):
  - Shift left: SEC_U←digit, SEC_T←old SEC_U, MIN←old SEC_T; old MIN is discarded.
  - The key is ignored if the digit is >9, or if old SEC_U >5 (SEC_T would become illegal).
  - An accepted key moves IDLE→SET.
- START:
  - From SET or PAUSE, with DOOR_OPEN=0 and time ≠0:00, go to COOK and clear the prescaler.
  - Otherwise START is ignored. START in COOK, IDLE or DONE is ignored.
- COOK: prescaler counts 0..CLK_PER_SEC-1. On terminal count, the time decrements by 1 s with BCD borrow: SEC_U 0→9 borrows SEC_T; SEC_T 0→5 borrows MIN.
  - A decrement that yields 0:00 moves to DONE in the same edge.
- DOOR_OPEN=1 in COOK → PAUSE. The prescaler is frozen and later cleared on resume.
- STOP:
  - COOK → PAUSE.
  - PAUSE or SET → IDLE with time cleared.
  - DONE → IDLE.
  - No effect in IDLE.
- DONE: time reads 0:00. Behaviour depends on DONE_BEEP_EN (see Configuration).
- MAG_ON = (STATE==COOK) & ~DOOR_OPEN, combinational. The door gates it with no clock delay.

## Timing

- Reset values (async, immediate): STATE=IDLE, MIN=SEC_T=SEC_U=0, prescaler=0, beep counter=0, BEEP=0, MAG_ON=0.
- All outputs except MAG_ON are registered.
- START strobe at edge n: STATE=COOK and MAG_ON=1 after edge n.
- First decrement: CLK_PER_SEC edges after COOK entry, then every CLK_PER_SEC edges.
- Resume after pause: a full CLK_PER_SEC period elapses before the next decrement. Partial seconds are discarded.
- Key digit is visible on SEC_U one edge after KEY_VALID.
- Simultaneous events:
  - STOP with a tick: STOP wins and no decrement occurs.
  - Door opening on the tick that reaches 0:00: go to PAUSE at 0:00. A later START is ignored; STOP clears to IDLE.
- CLEAR mid-COOK: MAG_ON drops asynchronously and all state returns to reset values.

## Configuration

- DONE_BEEP_EN defined:
  - DONE holds BEEP=1 for BEEP_SECONDS×CLK_PER_SEC cycles, then goes to IDLE.
  - STOP or KEY_VALID in DONE ends the beep early and goes to IDLE. A key press in DONE is not entered as a digit.
- DONE_BEEP_EN undefined:
  - BEEP is tied to 0 and the beep counter is removed.
  - DONE lasts exactly one cycle, then goes to IDLE.

## Structure

- Shared package `microwave_pkg`: state encodings, the STATE width, and BCD limit constants (9, 5).
- One sub-module, `bcd_down_digit`: a single BCD digit with
  - inputs: parameterised max, load, decrement-enable, borrow-in;
  - outputs: borrow-out, zero flag.
- Instantiated three times for MIN, SEC_T and SEC_U. The FSM and prescaler live in the top.

## Test plan

Run with CLK_PER_SEC=4, BEEP_SECONDS=2.

1. Keys 1,0,5 → MIN=1, SEC_T=0, SEC_U=5, STATE=SET. Key 7 is then ignored because SEC_U=5>5 fails? No: old SEC_U=5 is allowed, so it shifts to 0:57, MIN=0.
2. Enter 1:00, then START → MAG_ON=1 next edge. After 4 cycles, display reads 0:59. After 240 cycles from START, STATE=DONE and MAG_ON=0.
3. Enter 0:03, START, then DOOR_OPEN=1 on cycle 6 → MAG_ON=0 the same cycle, STATE=PAUSE, display 0:02. Close the door and START → reaches 0:00 and DONE 8 cycles later.
4. With DONE_BEEP_EN: 0:01 cook → BEEP=1 for 8 cycles, then IDLE. Repeat, pressing STOP during the beep → IDLE next edge.
5. START in IDLE with time 0:00, and START with the door open in SET → STATE unchanged, MAG_ON=0.
6. CLEAR pulsed mid-COOK at 0:30 → all outputs zero immediately, STATE=IDLE.
